// File: rtl/lsu_mem_master.sv
// MEM-stage load/store master for a word-only data memory: lane extract/extend on loads,
// read-modify-write for sub-word stores. Sub-word support is built only with LSU_SUBWORD_EN.
module lsu_mem_master #(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  // state    | meaning
  // S_IDLE   | waiting for req_valid; fault check on the incoming request
  // S_RD     | memory read for a load, extended lane captured into resp_rdata
  // S_RMW_RD | read of the word a sub-word store will merge into
  // S_WR     | memory write of a full word
  // S_RESP   | one-cycle resp_valid
`ifdef LSU_SUBWORD_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_addr_w;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [31:0] r_resp_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_bad_size;
  logic        w_misalign;
  logic        w_range;
  logic        w_req_fault;
  logic [31:0] w_load;
  logic [31:0] w_wr_word;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_merge;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_merged;
`else
  logic        w_unused_ok;
  assign w_unused_ok = req_signed;
`endif

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
`ifdef LSU_SUBWORD_EN
    w_bad_size = (req_size == 2'b11);
    w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    w_bad_size = (req_size != 2'b10);
    w_misalign = (req_addr[1:0] != 2'b00);
`endif
    w_range     = ({2'b00, req_addr[31:2]} >= DM_WORDS);
    w_req_fault = w_bad_size || w_misalign || w_range;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_fault)
            w_state_nxt = S_RESP;
          else if (!req_write)
            w_state_nxt = S_RD;
`ifdef LSU_SUBWORD_EN
          else if (req_size != 2'b10)
            w_state_nxt = S_RMW_RD;
`endif
          else
            w_state_nxt = S_WR;
        end
      end
      S_RD:     w_state_nxt = S_RESP;
`ifdef LSU_SUBWORD_EN
      S_RMW_RD: w_state_nxt = S_WR;
`endif
      S_WR:     w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  always_comb begin
    w_lane8 = mem_rdata[7:0];
    case (r_off)
      2'd0: w_lane8 = mem_rdata[7:0];
      2'd1: w_lane8 = mem_rdata[15:8];
      2'd2: w_lane8 = mem_rdata[23:16];
      2'd3: w_lane8 = mem_rdata[31:24];
      default: w_lane8 = mem_rdata[7:0];
    endcase
    w_lane16 = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_lane8[7]}}, w_lane8};
      2'b01:   w_load = {{16{r_signed & w_lane16[15]}}, w_lane16};
      default: w_load = mem_rdata;
    endcase
  end

  // Target lane replaced from the right-aligned store data, other lanes kept from the read.
  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_merge;
      endcase
    end else if (r_off[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
    w_wr_word = (r_size == 2'b10) ? r_wdata : w_merged;
  end
`else
  assign w_load    = mem_rdata;
  assign w_wr_word = r_wdata;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_addr_w     <= '0;
      r_wdata      <= '0;
      r_pc         <= '0;
      r_resp_rdata <= '0;
      r_fault      <= 1'b0;
`ifdef LSU_SUBWORD_EN
      r_off        <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_merge      <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr_w <= req_addr[31:2];
        r_wdata  <= req_wdata;
        r_pc     <= req_pc;
`ifdef LSU_SUBWORD_EN
        r_off    <= req_addr[1:0];
        r_size   <= req_size;
        r_signed <= req_signed;
`endif
      end
      // Response registers change only on the edge entering S_RESP, so they hold otherwise.
      if (w_accept && w_req_fault) begin
        r_resp_rdata <= '0;
        r_fault      <= 1'b1;
      end
      if (r_state == S_RD) begin
        r_resp_rdata <= w_load;
        r_fault      <= 1'b0;
      end
      if (r_state == S_WR) begin
        r_resp_rdata <= '0;
        r_fault      <= 1'b0;
      end
`ifdef LSU_SUBWORD_EN
      if (r_state == S_RMW_RD)
        r_merge <= mem_rdata;
`endif
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign fault      = r_fault;
`ifdef LSU_SUBWORD_EN
  assign mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
`else
  assign mem_read   = (r_state == S_RD);
`endif
  assign mem_write  = (r_state == S_WR);
  assign mem_addr   = busy ? {r_addr_w, 2'b00} : 32'h0;
  assign mem_pc     = busy ? r_pc : 32'h0;
  assign mem_wdata  = mem_write ? w_wr_word : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed table, reset abort, and random traffic
// against a word-array memory model. Follows LSU_SUBWORD_EN like the design.
`timescale 1ns/1ps
module tb_lsu_mem_master;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  localparam int DMW = 1024;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        busy, resp_valid, fault, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_pc, mem_rdata;

  always #5 Clock = ~Clock;

  lsu_mem_master #(.DM_WORDS(DMW)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [DMW];
  logic [31:0] exp_mem [DMW];
  logic [31:0] last_wdata, last_waddr;

  assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge Clock) begin
    if (mem_write && !Reset) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      last_wdata <= mem_wdata;
      last_waddr <= mem_addr;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] rdata;
    bit          flt;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
  } exp_t;

  // Reference: memory as a word array, lanes handled with shifts and modulo arithmetic.
  task automatic model(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int off;
    int idx;
    logic [31:0] w, v, mask;
    bit flt;
    off = int'(a % 4);
    e.rdata = 0; e.flt = 0; e.lat = 0; e.nrd = 0; e.nwr = 0; e.wword = 0;
    flt = (sz == 3) || (!SUB && sz != 2) || (sz == 1 && off % 2 == 1) ||
          (sz == 2 && off != 0) || (a / 4 >= DMW);
    if (flt) begin
      e.flt = 1; e.lat = 1;
      return;
    end
    idx = int'(a / 4);
    w = exp_mem[idx];
    if (!wr) begin
      if (sz == 0) begin
        v = (w >> (8 * off)) % 256;
        if (sg && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 1) begin
        v = (w >> (8 * off)) % 65536;
        if (sg && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
        v = w;
      end
      e.rdata = v; e.lat = 2; e.nrd = 1;
    end else if (sz == 2) begin
      exp_mem[idx] = wd;
      e.wword = wd; e.lat = 2; e.nwr = 1;
    end else begin
      mask = ((sz == 0) ? 32'd255 : 32'd65535) << (8 * off);
      v = (w & ~mask) | ((wd << (8 * off)) & mask);
      exp_mem[idx] = v;
      e.wword = v; e.lat = 3; e.nrd = 1; e.nwr = 1;
    end
  endtask

  // Issues one request and observes it until resp_valid; bad flags any protocol slip.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] rdata, output bit flt, output int lat,
                        output int nrd, output int nwr, output bit bad);
    @(negedge Clock);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = pc;
    @(posedge Clock); #1;
    req_valid = 0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    lat = 0; nrd = 0; nwr = 0; bad = 0; rdata = 'x; flt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clock);
      if (!busy) bad = 1;
      if (mem_addr !== {a[31:2], 2'b00} || mem_pc !== pc) bad = 1;
      if (mem_read && mem_write) bad = 1;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (resp_valid) begin
        lat = j + 1; rdata = resp_rdata; flt = fault;
        break;
      end
    end
    @(posedge Clock);
    @(negedge Clock);
    if (busy || resp_valid || mem_read || mem_write || mem_addr !== 0 || mem_pc !== 0 ||
        resp_rdata !== rdata || fault !== flt) bad = 1;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          flt;
    int          lat;
    logic [31:0] ww;
  } vec_t;

  initial begin
    vec_t tbl[$];
    exp_t e;
    logic [31:0] rdata;
    bit flt, bad, rv;
    int lat, nrd, nwr, xrd, xwr, diffs;
    logic [31:0] a, wd;
    bit wr, sg;
    logic [1:0] sz;

    for (int i = 0; i < DMW; i++) mem[i] = (i * 32'h00010003) ^ 32'hC3C30000;
    mem[8]    = 32'h11223344;
    mem[12]   = 32'h8000F0FF;
    mem[1023] = 32'hCAFEF00D;
    for (int i = 0; i < DMW; i++) exp_mem[i] = mem[i];

    tbl.push_back('{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 32'hDEADBEEF});
    tbl.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 32'h0});
    tbl.push_back('{1, 2'd0, 0, 32'h21, 32'h000000AA, 32'h0, !SUB, SUB ? 3 : 1, 32'h1122AA44});
    tbl.push_back('{0, 2'd2, 0, 32'h20, 32'h0, SUB ? 32'h1122AA44 : 32'h11223344, 0, 2, 32'h0});
    tbl.push_back('{0, 2'd0, 1, 32'h30, 32'h0, SUB ? 32'hFFFFFFFF : 32'h0, !SUB, SUB ? 2 : 1, 32'h0});
    tbl.push_back('{0, 2'd1, 0, 32'h32, 32'h0, SUB ? 32'h00008000 : 32'h0, !SUB, SUB ? 2 : 1, 32'h0});
    tbl.push_back('{0, 2'd1, 1, 32'h32, 32'h0, SUB ? 32'hFFFF8000 : 32'h0, !SUB, SUB ? 2 : 1, 32'h0});
    tbl.push_back('{0, 2'd0, 0, 32'h33, 32'h0, SUB ? 32'h00000080 : 32'h0, !SUB, SUB ? 2 : 1, 32'h0});
    tbl.push_back('{0, 2'd1, 0, 32'h31, 32'h0, 32'h0, 1, 1, 32'h0});
    tbl.push_back('{1, 2'd2, 0, 32'h22, 32'h12345678, 32'h0, 1, 1, 32'h0});
    tbl.push_back('{0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 32'h0});
    tbl.push_back('{0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 32'h0});
    tbl.push_back('{0, 2'd2, 0, 32'h0FFC, 32'h0, 32'hCAFEF00D, 0, 2, 32'h0});
    tbl.push_back('{1, 2'd1, 0, 32'h32, 32'h00001234, 32'h0, !SUB, SUB ? 3 : 1, 32'h1234F0FF});
    tbl.push_back('{0, 2'd2, 0, 32'h30, 32'h0, SUB ? 32'h1234F0FF : 32'h8000F0FF, 0, 2, 32'h0});

    Reset = 1; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; req_pc = 0;
    repeat (3) @(posedge Clock);
    #1 Reset = 0;
    @(negedge Clock);
    chk("reset_flags", {31'h0, busy | resp_valid | fault | mem_read | mem_write}, 32'h0);
    chk("reset_buses", resp_rdata | mem_addr | mem_wdata | mem_pc, 32'h0);

    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, e);
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, 32'h00400000 + 4 * i,
             rdata, flt, lat, nrd, nwr, bad);
      xwr = (tbl[i].wr && !tbl[i].flt) ? 1 : 0;
      xrd = (!tbl[i].flt && (!tbl[i].wr || tbl[i].sz != 2)) ? 1 : 0;
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
      chk($sformatf("tbl%0d_fault", i), {31'h0, flt}, {31'h0, tbl[i].flt});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_reads", i), nrd, xrd);
      chk($sformatf("tbl%0d_writes", i), nwr, xwr);
      chk($sformatf("tbl%0d_protocol", i), {31'h0, bad}, 32'h0);
      if (xwr == 1) begin
        chk($sformatf("tbl%0d_wdata", i), last_wdata, tbl[i].ww);
        chk($sformatf("tbl%0d_waddr", i), last_waddr, {tbl[i].addr[31:2], 2'b00});
      end
    end

    // Reset in the first busy cycle (RMW_RD for a sub-word store, RD otherwise) aborts it.
    @(negedge Clock);
    req_valid = 1; req_write = SUB; req_size = SUB ? 2'd0 : 2'd2; req_signed = 0;
    req_addr = SUB ? 32'h21 : 32'h20; req_wdata = 32'h55; req_pc = 32'h00400100;
    @(posedge Clock); #1 req_valid = 0;
    @(negedge Clock);
    chk("abort_read_strobe", {31'h0, mem_read}, 32'h1);
    Reset = 1;
    @(posedge Clock); #1 Reset = 0;
    @(negedge Clock);
    chk("abort_flags", {31'h0, busy | resp_valid | fault | mem_read | mem_write}, 32'h0);
    chk("abort_buses", resp_rdata | mem_addr | mem_wdata | mem_pc, 32'h0);
    rv = 0;
    repeat (4) begin
      @(negedge Clock);
      rv = rv | resp_valid;
    end
    chk("abort_no_resp", {31'h0, rv}, 32'h0);
    model(0, 2'd2, 0, 32'h20, 32'h0, e);
    do_req(0, 2'd2, 0, 32'h20, 32'h0, 32'h00400104, rdata, flt, lat, nrd, nwr, bad);
    chk("abort_reload", rdata, e.rdata);
    chk("abort_reload_latency", lat, 2);

    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) a = $urandom;
      else if ($urandom_range(0, 9) == 0) a = 4 * $urandom_range(1020, 1030);
      else a = 4 * $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) a = a + $urandom_range(1, 3);
      wd = $urandom;
      model(wr, sz, sg, a, wd, e);
      do_req(wr, sz, sg, a, wd, 32'h00500000 + 4 * t, rdata, flt, lat, nrd, nwr, bad);
      chk($sformatf("rnd%0d_rdata", t), rdata, e.rdata);
      chk($sformatf("rnd%0d_fault", t), {31'h0, flt}, {31'h0, e.flt});
      chk($sformatf("rnd%0d_latency", t), lat, e.lat);
      chk($sformatf("rnd%0d_reads", t), nrd, e.nrd);
      chk($sformatf("rnd%0d_writes", t), nwr, e.nwr);
      chk($sformatf("rnd%0d_protocol", t), {31'h0, bad}, 32'h0);
      if (e.nwr == 1) chk($sformatf("rnd%0d_wdata", t), last_wdata, e.wword);
    end

    diffs = 0;
    for (int i = 0; i < DMW; i++) if (mem[i] !== exp_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
